// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in / serial-out controller:
//   - FSM state encoding (IDLE = 0, SHIFT = 1), kept as plain localparams so
//     the encoding is visible to legacy tooling and waveform viewers.
//   - cnt_width(): width of the bit-position counter for a given word width.
// -----------------------------------------------------------------------------
package piso_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Counter wide enough to hold 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage : piso_pkg

// File: rtl/piso_shift.sv
// -----------------------------------------------------------------------------
// piso_shift
// WIDTH-bit shift register datapath. Load has priority over shift. The serial
// output is always the bit at the "outgoing" end of the register, so after
// k shifts it presents word bit (MSB_FIRST ? WIDTH-1-k : k).
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset, clears the register
//   load_i   capture data_i this cycle
//   shift_i  advance one position this cycle (ignored when load_i = 1)
//   data_i   parallel word
//   sout_o   current outgoing bit
// -----------------------------------------------------------------------------
module piso_shift #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             sout_o
);

  logic [WIDTH-1:0] sreg_q, sreg_d;

  // NOTE: combinational blocks assign a default first and use blocking '=';
  // every path then drives sreg_d, so no latch can be inferred.
  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                         : {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values. The register is small and reset-cleared so no stale word
  // can leak out after an aborted frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign sout_o = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule : piso_shift

// File: rtl/piso_ctrl.sv
// -----------------------------------------------------------------------------
// piso_ctrl
// Parallel-in / serial-out controller with a valid/ready input handshake and a
// stallable serial output. A word is accepted in IDLE or on the last bit of the
// current frame (zero-gap back-to-back frames); its first bit appears one cycle
// after the handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset (0 = reset)
//   in_valid    upstream offers in_data
//   in_data     parallel word, sampled only on a handshake
//   in_ready    word can be accepted this cycle
//   shift_en    downstream advance enable; 0 holds the current bit
//   sout        current serial bit (0 when idle)
//   sout_valid  sout carries a frame bit
//   sout_first  current bit is the first of its frame
//   sout_last   current bit is the last of its frame
//   busy        a frame is in progress
// -----------------------------------------------------------------------------
module piso_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int                 CNT_W   = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic shifting;
  logic at_last;
  logic handshake;
  logic advance;
  logic serial_bit;

  assign shifting  = (state_q == ST_SHIFT);
  assign at_last   = shifting && (cnt_q == CNT_MAX);
  assign in_ready  = !shifting || (at_last && shift_en);
  assign handshake = in_valid && in_ready;
  // Mid-frame advance only; the last bit either reloads or ends the frame.
  assign advance   = shifting && shift_en && !at_last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (handshake) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
    end else if (at_last && shift_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (advance) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (handshake),
    .shift_i (advance),
    .data_i  (in_data),
    .sout_o  (serial_bit)
  );

  // All frame outputs are gated by state so IDLE presents all-zero.
  assign sout       = shifting && serial_bit;
  assign sout_valid = shifting;
  assign sout_first = shifting && (cnt_q == '0);
  assign sout_last  = at_last;
  assign busy       = shifting;

endmodule : piso_ctrl

// File: tb/tb_piso_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piso_ctrl
// Directed bench for piso_ctrl at WIDTH = 4. Two instances share all inputs:
// u_msb (MSB_FIRST = 1) and u_lsb (MSB_FIRST = 0). Inputs change 1 ns after
// each rising edge; outputs are checked at that point as well.
// -----------------------------------------------------------------------------
module tb_piso_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         shift_en;

  logic m_ready, m_sout, m_valid, m_first, m_last, m_busy;
  logic l_ready, l_sout, l_valid, l_first, l_last, l_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (m_ready),
    .shift_en   (shift_en),
    .sout       (m_sout),
    .sout_valid (m_valid),
    .sout_first (m_first),
    .sout_last  (m_last),
    .busy       (m_busy)
  );

  piso_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (l_ready),
    .shift_en   (shift_en),
    .sout       (l_sout),
    .sout_valid (l_valid),
    .sout_first (l_first),
    .sout_last  (l_last),
    .busy       (l_busy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected MSB-instance frame outputs {sout, valid, first, last, busy}.
  task automatic expect_msb(input string tag, input logic b, input logic first, input logic last);
    check(tag, {3'b0, m_sout, m_valid, m_first, m_last, m_busy},
          {3'b0, b, 1'b1, first, last, 1'b1});
  endtask

  task automatic expect_msb_idle(input string tag);
    check(tag, {3'b0, m_sout, m_valid, m_first, m_last, m_busy}, 8'h00);
  endtask

  logic [3:0] exp_a;
  logic [7:0] exp_b2b;

  initial begin
    // ---------------- reset, handshakes ignored ----------------
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'b1111;
    shift_en = 1'b1;
    tick();
    tick();
    expect_msb_idle("reset_outputs_msb");
    check("reset_outputs_lsb", {3'b0, l_sout, l_valid, l_first, l_last, l_busy}, 8'h00);
    check("reset_ready", {6'b0, m_ready, l_ready}, 8'h03);

    // ---------------- single frame 1011, both bit orders ----------------
    in_valid = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b1011;
    tick();                       // first edge after release: handshake
    in_valid = 1'b0;
    in_data  = 4'b0100;           // must not disturb the frame
    exp_a    = 4'b1101;           // LSB-first stream of 1011
    expect_msb("single_c1", 1'b1, 1'b1, 1'b0);
    check("lsb_c1", {7'b0, l_sout}, {7'b0, exp_a[3]});
    check("single_c1_ready", {7'b0, m_ready}, 8'h00);
    tick();
    expect_msb("single_c2", 1'b0, 1'b0, 1'b0);
    check("lsb_c2", {7'b0, l_sout}, {7'b0, exp_a[2]});
    tick();
    expect_msb("single_c3", 1'b1, 1'b0, 1'b0);
    check("lsb_c3", {7'b0, l_sout}, {7'b0, exp_a[1]});
    tick();
    expect_msb("single_c4", 1'b1, 1'b0, 1'b1);
    check("lsb_c4", {6'b0, l_sout, l_last}, {6'b0, exp_a[0], 1'b1});
    check("single_c4_ready", {7'b0, m_ready}, 8'h01);
    tick();
    expect_msb_idle("single_c5_idle");
    check("single_c5_ready", {7'b0, m_ready}, 8'h01);

    // ---------------- stall on third bit of 1100 ----------------
    in_valid = 1'b1;
    in_data  = 4'b1100;
    tick();
    in_valid = 1'b0;
    expect_msb("stall_c1", 1'b1, 1'b1, 1'b0);
    tick();
    expect_msb("stall_c2", 1'b1, 1'b0, 1'b0);
    tick();
    expect_msb("stall_c3", 1'b0, 1'b0, 1'b0);
    shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_msb($sformatf("stall_hold%0d", i), 1'b0, 1'b0, 1'b0);
      check($sformatf("stall_hold%0d_ready", i), {7'b0, m_ready}, 8'h00);
    end
    shift_en = 1'b1;
    tick();
    expect_msb("stall_c4_last", 1'b0, 1'b0, 1'b1);
    shift_en = 1'b0;
    #1;
    check("stall_last_noen_ready", {7'b0, m_ready}, 8'h00);
    tick();
    expect_msb("stall_last_held", 1'b0, 1'b0, 1'b1);
    shift_en = 1'b1;
    #1;
    check("stall_last_en_ready", {7'b0, m_ready}, 8'h01);
    tick();
    expect_msb_idle("stall_idle");

    // ---------------- back-to-back 1010 then 0110 ----------------
    exp_b2b  = 8'b1010_0110;
    in_valid = 1'b1;
    in_data  = 4'b1010;
    tick();
    in_data  = 4'b0110;           // offered while busy: only taken on last bit
    for (int i = 0; i < 8; i++) begin
      expect_msb($sformatf("b2b_bit%0d", i), exp_b2b[7-i], (i % 4) == 0, (i % 4) == 3);
      check($sformatf("b2b_bit%0d_ready", i), {7'b0, m_ready}, {7'b0, ((i % 4) == 3)});
      if (i == 3) in_data = 4'b0110;
      if (i == 4) in_data = 4'b1111; // still offered, must not load mid-frame
      if (i == 7) in_valid = 1'b0;
      tick();
    end
    expect_msb_idle("b2b_idle");

    // ---------------- mid-frame asynchronous reset ----------------
    in_valid = 1'b1;
    in_data  = 4'b1011;
    tick();
    in_valid = 1'b0;
    expect_msb("rst_c1", 1'b1, 1'b1, 1'b0);
    tick();
    expect_msb("rst_c2", 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    expect_msb_idle("rst_async_clear");
    check("rst_async_ready", {7'b0, m_ready}, 8'h01);
    tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b0001;
    tick();
    in_valid = 1'b0;
    expect_msb("post_rst_c1", 1'b0, 1'b1, 1'b0);
    tick();
    expect_msb("post_rst_c2", 1'b0, 1'b0, 1'b0);
    tick();
    expect_msb("post_rst_c3", 1'b0, 1'b0, 1'b0);
    tick();
    expect_msb("post_rst_c4", 1'b1, 1'b0, 1'b1);
    tick();
    expect_msb_idle("post_rst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_piso_ctrl
